// File: rtl/mips_regfile_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS mono-cycle register file: default data and
// address widths, register count, the hardwired-zero register index and the
// basic word/address typedefs used by the regfile, its write decoder and its
// bus interface.
// -----------------------------------------------------------------------------
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 2 ** ADDR_W;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] word_t;

endpackage

// File: rtl/mips_regfile_if.sv
// -----------------------------------------------------------------------------
// mips_regfile_if
// Bus between instruction decode / write-back and the register file.
//   rs_addr, rt_addr      : read port addresses
//   rd1, rd2              : read data
//   uninit_rd1/2          : read port addresses a register not written since reset
//   wr_en, wr_addr,wr_data: write port (RegWrite, dest-mux output, write-back data)
// Modports:
//   master : datapath side (drives addresses and write port)
//   slave  : register file side
// -----------------------------------------------------------------------------
interface mips_regfile_if #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W
);

  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              uninit_rd1;
  logic              uninit_rd2;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output rs_addr, rt_addr, wr_en, wr_addr, wr_data,
    input  rd1, rd2, uninit_rd1, uninit_rd2
  );

  modport slave (
    input  rs_addr, rt_addr, wr_en, wr_addr, wr_data,
    output rd1, rd2, uninit_rd1, uninit_rd2
  );

endinterface

// File: rtl/mips_regfile_wr_decode.sv
// -----------------------------------------------------------------------------
// regfile_wr_decode
// Combinational one-hot decode of the register-file write address.
// Ports:
//   wr_en_i   : write strobe
//   wr_addr_i : write address
//   we_o      : one enable per register; bit 0 is always low so the
//               hardwired-zero register can never be written
// -----------------------------------------------------------------------------
module regfile_wr_decode
  import mips_pkg::*;
#(
  parameter int ADDR_W = mips_pkg::ADDR_W
) (
  input  logic                   wr_en_i,
  input  logic [ADDR_W-1:0]      wr_addr_i,
  output logic [2**ADDR_W-1:0]   we_o
);

  always_comb begin
    we_o = '0;
    if (wr_en_i) begin
      we_o[wr_addr_i] = 1'b1;
    end
    we_o[REG_ZERO] = 1'b0;
  end

endmodule

// File: rtl/mips_regfile.sv
// -----------------------------------------------------------------------------
// mips_regfile
// 32 x 32-bit MIPS general-purpose register file: two combinational read
// ports and one synchronous write port, plus a written-since-reset bitmap
// that flags reads of stale registers.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset (clears registers and bitmap,
//           forces all read outputs to 0 while low)
//   bus   : mips_regfile_if.slave (read addresses/data, uninit flags,
//           write port)
// Build option:
//   REGFILE_BYPASS_EN : when defined, a write in the current cycle is
//                       forwarded to any read port addressing the same
//                       register; otherwise reads return pre-edge state.
// -----------------------------------------------------------------------------
module mips_regfile
  import mips_pkg::*;
#(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mips_regfile_if.slave        bus
);

  localparam int NR = 2 ** ADDR_W;

  logic [DATA_W-1:0] reg_q [NR];
  logic [DATA_W-1:0] reg_d [NR];
  logic [NR-1:0]     valid_q;
  logic [NR-1:0]     valid_d;
  logic [NR-1:0]     we;

  regfile_wr_decode #(
    .ADDR_W (ADDR_W)
  ) u_wr_decode (
    .wr_en_i   (bus.wr_en),
    .wr_addr_i (bus.wr_addr),
    .we_o      (we)
  );

  // Next state: only the decoded register takes the write-back value.
  // we[0] is never set, so reg_q[0] stays at its reset value of zero.
  always_comb begin
    for (int i = 0; i < NR; i++) begin
      reg_d[i] = we[i] ? bus.wr_data : reg_q[i];
    end
    valid_d    = valid_q | we;
    valid_d[0] = 1'b1;
  end

  // Reset wins over a concurrent write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) begin
        reg_q[i] <= '0;
      end
      valid_q <= NR'(1);
    end else begin
      reg_q   <= reg_d;
      valid_q <= valid_d;
    end
  end

  // Read port 1
  always_comb begin
    bus.rd1        = reg_q[bus.rs_addr];
    bus.uninit_rd1 = ~valid_q[bus.rs_addr];
`ifdef REGFILE_BYPASS_EN
    if (bus.wr_en && (bus.wr_addr != ADDR_W'(REG_ZERO)) && (bus.wr_addr == bus.rs_addr)) begin
      bus.rd1        = bus.wr_data;
      bus.uninit_rd1 = 1'b0;
    end
`endif
    if (bus.rs_addr == ADDR_W'(REG_ZERO)) begin
      bus.rd1        = '0;
      bus.uninit_rd1 = 1'b0;
    end
    if (!rst_n) begin
      bus.rd1        = '0;
      bus.uninit_rd1 = 1'b0;
    end
  end

  // Read port 2
  always_comb begin
    bus.rd2        = reg_q[bus.rt_addr];
    bus.uninit_rd2 = ~valid_q[bus.rt_addr];
`ifdef REGFILE_BYPASS_EN
    if (bus.wr_en && (bus.wr_addr != ADDR_W'(REG_ZERO)) && (bus.wr_addr == bus.rt_addr)) begin
      bus.rd2        = bus.wr_data;
      bus.uninit_rd2 = 1'b0;
    end
`endif
    if (bus.rt_addr == ADDR_W'(REG_ZERO)) begin
      bus.rd2        = '0;
      bus.uninit_rd2 = 1'b0;
    end
    if (!rst_n) begin
      bus.rd2        = '0;
      bus.uninit_rd2 = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_regfile.sv
// -----------------------------------------------------------------------------
// tb_mips_regfile
// Scoreboard bench for mips_regfile. The driver applies one vector per clock
// just after the rising edge and pushes the hand-computed read-port values
// expected for that cycle; a monitor samples on the falling edge and pops.
// -----------------------------------------------------------------------------
module tb_mips_regfile;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mips_regfile_if bus ();

  mips_regfile dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] rd1;
    logic        u1;
    logic [31:0] rd2;
    logic        u2;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  function automatic logic [31:0] sweep_val(input int i);
    logic [31:0] v;
    v = 32'(i) * 32'h01010101;
    return v;
  endfunction

  task automatic drive(input logic rn, input logic [4:0] rs, input logic [4:0] rt,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd);
    @(posedge clk);
    #1;
    rst_n       = rn;
    bus.rs_addr = rs;
    bus.rt_addr = rt;
    bus.wr_en   = we;
    bus.wr_addr = wa;
    bus.wr_data = wd;
  endtask

  task automatic exp_push(input string nm, input logic [31:0] r1, input logic u1,
                          input logic [31:0] r2, input logic u2);
    exp_t e;
    e.name = nm;
    e.rd1  = r1;
    e.u1   = u1;
    e.rd2  = r2;
    e.u2   = u2;
    q.push_back(e);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if (bus.rd1 !== e.rd1 || bus.uninit_rd1 !== e.u1 ||
          bus.rd2 !== e.rd2 || bus.uninit_rd2 !== e.u2) begin
        bad++;
        $display("FAIL %s: got rd1=%h u1=%b rd2=%h u2=%b, want rd1=%h u1=%b rd2=%h u2=%b",
                 e.name, bus.rd1, bus.uninit_rd1, bus.rd2, bus.uninit_rd2,
                 e.rd1, e.u1, e.rd2, e.u2);
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    bus.rs_addr = '0;
    bus.rt_addr = '0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;

    // Reset held two cycles; outputs forced to zero regardless of address.
    drive(1'b0, 5'd5, 5'd0, 1'b0, 5'd0, 32'h0);
    exp_push("rst_hold0", 32'h0, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 5'd8, 5'd3, 1'b0, 5'd0, 32'h0);
    exp_push("rst_hold1", 32'h0, 1'b0, 32'h0, 1'b0);

    // Post-reset state
    drive(1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 32'h0);
    exp_push("post_rst", 32'h0, 1'b1, 32'h0, 1'b0);

    // Basic write/read of r8
    drive(1'b1, 5'd8, 5'd8, 1'b1, 5'd8, 32'hDEADBEEF);
    if (BYP) exp_push("wr_r8_same", 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0);
    else     exp_push("wr_r8_same", 32'h0, 1'b1, 32'h0, 1'b1);
    drive(1'b1, 5'd8, 5'd8, 1'b0, 5'd0, 32'h0);
    exp_push("rd_r8", 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0);

    // r0 protection
    drive(1'b1, 5'd0, 5'd8, 1'b1, 5'd0, 32'hFFFFFFFF);
    exp_push("wr_r0_same", 32'h0, 1'b0, 32'hDEADBEEF, 1'b0);
    drive(1'b1, 5'd0, 5'd8, 1'b0, 5'd0, 32'h0);
    exp_push("rd_r0", 32'h0, 1'b0, 32'hDEADBEEF, 1'b0);
    drive(1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 32'h0);
    exp_push("r0_no_side", 32'h0, 1'b1, 32'h0, 1'b0);

    // Same-cycle read/write of r3
    drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 32'h1);
    drive(1'b1, 5'd3, 5'd3, 1'b1, 5'd3, 32'h2);
    if (BYP) exp_push("rw_same_r3", 32'h2, 1'b0, 32'h2, 1'b0);
    else     exp_push("rw_same_r3", 32'h1, 1'b0, 32'h1, 1'b0);
    drive(1'b1, 5'd3, 5'd3, 1'b0, 5'd0, 32'h0);
    exp_push("rw_next_r3", 32'h2, 1'b0, 32'h2, 1'b0);

    // Reset beats write
    drive(1'b0, 5'd10, 5'd10, 1'b1, 5'd10, 32'h55);
    exp_push("rst_vs_wr", 32'h0, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 5'd10, 5'd8, 1'b0, 5'd0, 32'h0);
    exp_push("rst_won", 32'h0, 1'b1, 32'h0, 1'b1);

    // Full sweep: write r1..r31 (port 1 watches the register being written)
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 5'(i), 5'd0, 1'b1, 5'(i), sweep_val(i));
      if (BYP) exp_push($sformatf("sweep_wr%0d", i), sweep_val(i), 1'b0, 32'h0, 1'b0);
      else     exp_push($sformatf("sweep_wr%0d", i), 32'h0, 1'b1, 32'h0, 1'b0);
    end
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 5'(i), 5'(31 - i), 1'b0, 5'd0, 32'h0);
      exp_push($sformatf("sweep_rd%0d", i), sweep_val(i), 1'b0, sweep_val(31 - i), 1'b0);
    end

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 4 && q.size() > 0; k++) begin
      @(posedge clk);
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending entries, want 0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_regfile.md
# mips_regfile

Register file for the MIPS mono-cycle datapath: 32 × 32-bit general-purpose registers, two combinational read ports (rs, rt) and one synchronous write port. The write port is fed by the 5-bit destination-select multiplexer. This block holds the 5-to-32 decode of that address. It also tracks which registers have been written since reset, so the bench and debug logic can flag reads of stale state. It sits between instruction decode and the ALU, and takes its write-back from the ALU/memory result mux.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; register count NREGS = 2**ADDR_W
- clk  input  1  rising-edge clock for all state
- rst_n  input  1  reset; one clock, reset synchronous, active-low
- rs_addr  input  ADDR_W  read port 1 address
- rt_addr  input  ADDR_W  read port 2 address
- rd1  output  DATA_W  read data, port 1
- rd2  output  DATA_W  read data, port 2
- wr_en  input  1  write strobe (RegWrite)
- wr_addr  input  ADDR_W  write address (mux output rt/rd)
- wr_data  input  DATA_W  write-back data
- uninit_rd1  output  1  port 1 reads a register not written since reset
- uninit_rd2  output  1  port 2 reads a register not written since reset

## Operation
- State:
  - reg_q[NREGS] of DATA_W.
  - valid_q[NREGS], a written-since-reset bitmap.
- Write:
  - At a rising edge with rst_n=1, wr_en=1 and wr_addr≠0, reg_q[wr_addr] ← wr_data and valid_q[wr_addr] ← 1.
  - wr_addr=0 is ignored. No state changes.
- Register 0 is hardwired:
  - Reads of address 0 always return 0.
  - valid_q[0] is constant 1, so a read of address 0 never raises an uninit flag.
- Read:
  - Purely combinational from rs_addr/rt_addr.
  - rd1 = reg_q[rs_addr]; uninit_rd1 = ~valid_q[rs_addr]. Port 2 is identical with rt_addr.
- Both read ports may address the same register, including wr_addr. Both return identical data.
- Write enable is decoded one-hot: 32 enables, with bit 0 forced low.

## Timing
- Write latency: one clock. The new value is visible on rd* in the cycle after the write edge (see Configuration for same-cycle visibility).
- Reset:
  - While rst_n=0 at a rising edge, all reg_q ← 0, valid_q ← 32'h1, and any concurrent write is discarded. Reset wins over write.
  - While rst_n is low, rd1, rd2, uninit_rd1 and uninit_rd2 are forced to 0, independent of the addresses.
  - Post-reset values: rd*=0, uninit_rd*=1 for any nonzero address until that register is written.
- Reset asserted mid-program: all registers clear on that edge. Operation resumes on the first edge with rst_n=1.
- No stalls and no handshake. A write is accepted every cycle that wr_en=1.

## Configuration
- REGFILE_BYPASS_EN defined:
  - Same-cycle write-to-read forwarding on both ports.
  - When rst_n=1, wr_en=1, wr_addr≠0 and wr_addr equals rs_addr (or rt_addr), the matching port returns wr_data with its uninit flag at 0.
- REGFILE_BYPASS_EN undefined:
  - The port returns the stored pre-edge value and flag.
  - The new value appears only after the edge. This is standard mono-cycle behaviour.

## Structure
- Shared package mips_pkg holds:
  - the DATA_W/ADDR_W defaults
  - the NREGS constant
  - the localparam REG_ZERO = 5'd0
  - typedefs reg_addr_t (logic [4:0]) and word_t (logic [31:0])
- Sub-module regfile_wr_decode: combinational 5-to-32 one-hot decoder (wr_en, wr_addr → we[31:0], we[0] tied 0). The top instantiates one.

## Test plan
- Reset sequence:
  - rst_n=0 for 2 cycles, then release.
  - rs_addr=5, rt_addr=0 → rd1=0, uninit_rd1=1, rd2=0, uninit_rd2=0.
- Basic write/read:
  - Write 32'hDEADBEEF to r8.
  - Next cycle rs_addr=rt_addr=8 → rd1=rd2=32'hDEADBEEF and both uninit flags 0.
- Register 0 protection:
  - Write 32'hFFFFFFFF to r0.
  - Next cycle rs_addr=0 → rd1=0, uninit_rd1=0.
  - No other register changes.
- Same-cycle read/write:
  - r3=32'h1, then write 32'h2 to r3 while rs_addr=3 in the same cycle.
  - With REGFILE_BYPASS_EN: rd1=32'h2 in that cycle.
  - Without it: rd1=32'h1 in that cycle.
  - Either way rd1=32'h2 in the following cycle.
- Reset beats write:
  - rst_n=0 with wr_en=1, wr_addr=10, wr_data=32'h55.
  - After release, rs_addr=10 → rd1=0, uninit_rd1=1.
- Full sweep:
  - Write value (i×32'h01010101) to r1..r31, then read every pair (i, 31−i).
  - All values match, no uninit flags set, r0 reads 0.
